instr_encoder: RTL and testbench

Packs a field-level instruction request into a 32-bit RISC-V instruction word, the inverse of the core's instruction decoder. Used by the self-test and boot-stub generator to write instruction memory, and by the verification environment as a golden encoder. Valid/ready on both sides, one registered encode stage, 2-entry output buffer, saturating statistics counters.

---
 rtl/instr_encoder_pkg.sv | 84 ++++++++
 rtl/instr_encoder_imm_range_check.sv | 101 ++++++++++
 rtl/instr_encoder.sv | 124 ++++++++++++
 tb/tb_instr_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_enc_pkg
// Description : Shared types and constants for the RISC-V instruction encoder.
//               Op-class and format enums, opcode constants, the NOP word and
//               an opcode lookup helper.
//               Build macro INSTR_ENC_RV64_EN selects XLEN=64 and enables the
//               RV64-only classes (ARITHIW/ARITHW) and 6-bit ARITHI shamt.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_enc_pkg;

`ifdef INSTR_ENC_RV64_EN
  localparam int XLEN = 64;
`else
  localparam int XLEN = 32;
`endif

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_ARITHI  = 4'd7,
    CLS_ARITH   = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_ARITHIW = 4'd10,
    CLS_ARITHW  = 4'd11
  } op_class_e;

  // FMT_SH  : funct7 in [31:25], 5-bit shamt in [24:20]
  // FMT_SH6 : funct7[6:1] in [31:26], 6-bit shamt in [25:20]
  typedef enum logic [3:0] {
    FMT_R    = 4'd0,
    FMT_I    = 4'd1,
    FMT_SH   = 4'd2,
    FMT_SH6  = 4'd3,
    FMT_S    = 4'd4,
    FMT_B    = 4'd5,
    FMT_U    = 4'd6,
    FMT_J    = 4'd7,
    FMT_NONE = 4'd8
  } fmt_e;

  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_JAL     = 7'h6F;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_ARITHI  = 7'h13;
  localparam logic [6:0] OPC_ARITH   = 7'h33;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;
  localparam logic [6:0] OPC_ARITHIW = 7'h1B;
  localparam logic [6:0] OPC_ARITHW  = 7'h3B;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [6:0] opcode_of(input logic [3:0] cls);
    logic [6:0] opc;
    case (cls)
      CLS_LUI:     opc = OPC_LUI;
      CLS_AUIPC:   opc = OPC_AUIPC;
      CLS_JAL:     opc = OPC_JAL;
      CLS_JALR:    opc = OPC_JALR;
      CLS_BRANCH:  opc = OPC_BRANCH;
      CLS_LOAD:    opc = OPC_LOAD;
      CLS_STORE:   opc = OPC_STORE;
      CLS_ARITHI:  opc = OPC_ARITHI;
      CLS_ARITH:   opc = OPC_ARITH;
      CLS_SYSTEM:  opc = OPC_SYSTEM;
      CLS_ARITHIW: opc = OPC_ARITHIW;
      CLS_ARITHW:  opc = OPC_ARITHW;
      default:     opc = OPC_ARITHI;
    endcase
    return opc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_imm_range_check.sv
`default_nettype none
// ============================================================================
// Module      : imm_range_check
// Description : Combinational legality check for an encode request. Returns
//               the instruction format to build and an error flag for
//               out-of-range immediates, misaligned branch/jump offsets,
//               oversized shift amounts and invalid/disabled classes.
//               Honors build macro INSTR_ENC_RV64_EN.
// Ports       : cls    in  4    op class
//               funct3 in  3    selects shift variants of ARITHI/ARITHIW
//               imm    in  XLEN full signed immediate
//               err    out 1    request is illegal
//               fmt    out fmt_e format select
// Revision    : 1.0 - initial release
// ============================================================================
module imm_range_check
  import rv_enc_pkg::*;
(
  input  logic [3:0]      cls,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] imm,
  output logic            err,
  output fmt_e            fmt
);

  logic w_fit12, w_fit13, w_fit21, w_u_ok, w_shamt5_ok, w_is_shift;

  // A value fits in N signed bits when bits [XLEN-1:N-1] are all equal.
  assign w_fit12     = (imm[XLEN-1:11] == '0) || (&imm[XLEN-1:11]);
  assign w_fit13     = (imm[XLEN-1:12] == '0) || (&imm[XLEN-1:12]);
  assign w_fit21     = (imm[XLEN-1:20] == '0) || (&imm[XLEN-1:20]);
  assign w_shamt5_ok = (imm[XLEN-1:5] == '0);
  assign w_is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);

`ifdef INSTR_ENC_RV64_EN
  logic w_shamt6_ok;
  assign w_shamt6_ok = (imm[XLEN-1:6] == '0);
  // U immediate must also be a sign-extended 32-bit value on RV64.
  assign w_u_ok = (imm[11:0] == 12'd0) &&
                  ((imm[XLEN-1:31] == '0) || (&imm[XLEN-1:31]));
`else
  assign w_u_ok = (imm[11:0] == 12'd0);
`endif

  always_comb begin
    err = 1'b0;
    fmt = FMT_NONE;
    case (cls)
      CLS_LUI, CLS_AUIPC: begin
        fmt = FMT_U;
        err = !w_u_ok;
      end
      CLS_JAL: begin
        fmt = FMT_J;
        err = !w_fit21 || imm[0];
      end
      CLS_BRANCH: begin
        fmt = FMT_B;
        err = !w_fit13 || imm[0];
      end
      CLS_JALR, CLS_LOAD, CLS_SYSTEM: begin
        fmt = FMT_I;
        err = !w_fit12;
      end
      CLS_STORE: begin
        fmt = FMT_S;
        err = !w_fit12;
      end
      CLS_ARITH: fmt = FMT_R;
      CLS_ARITHI: begin
        if (w_is_shift) begin
`ifdef INSTR_ENC_RV64_EN
          fmt = FMT_SH6;
          err = !w_shamt6_ok;
`else
          fmt = FMT_SH;
          err = !w_shamt5_ok;
`endif
        end else begin
          fmt = FMT_I;
          err = !w_fit12;
        end
      end
`ifdef INSTR_ENC_RV64_EN
      CLS_ARITHIW: begin
        if (w_is_shift) begin
          fmt = FMT_SH;
          err = !w_shamt5_ok;
        end else begin
          fmt = FMT_I;
          err = !w_fit12;
        end
      end
      CLS_ARITHW: fmt = FMT_R;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs a field-level request into a 32-bit RISC-V instruction
//               word. Valid/ready on both sides, one registered encode stage
//               feeding a 2-entry output FIFO, saturating statistics counters.
//               Build macro INSTR_ENC_RV64_EN selects the RV64 variant.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready, in_class, in_funct3, in_funct7,
//               in_rd/in_rs1/in_rs2, in_imm[XLEN]   - request side
//               out_valid/out_ready, out_instr, out_err - result side
//               enc_cnt, err_cnt                      - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic        w_err;
  fmt_e        w_fmt;
  logic [6:0]  w_opc;
  logic [31:0] w_word;
  logic        w_push, w_pop;
  logic [1:0]  w_count_nxt;

  logic [31:0]      r_mem_instr [2];
  logic             r_mem_err   [2];
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_enc_cnt, r_err_cnt;

  imm_range_check u_imm_range_check (
    .cls    (in_class),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .err    (w_err),
    .fmt    (w_fmt)
  );

  assign w_opc = opcode_of(in_class);

  always_comb begin
    w_word = NOP_INSTR;
    if (!w_err) begin
      case (w_fmt)
        FMT_R:   w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, w_opc};
        FMT_I:   w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_opc};
        FMT_SH:  w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, w_opc};
        FMT_SH6: w_word = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, w_opc};
        FMT_S:   w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], w_opc};
        FMT_B:   w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], w_opc};
        FMT_U:   w_word = {in_imm[31:12], in_rd, w_opc};
        FMT_J:   w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, w_opc};
        default: w_word = NOP_INSTR;
      endcase
    end
  end

  // The encode stage registers straight into the FIFO slot at the write
  // pointer, so an accepted request is visible on the output the next cycle
  // when the FIFO was empty. S1 and FIFO occupancy are therefore the same
  // count, and in_ready is registered from the next occupancy.
  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = out_valid && out_ready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_err[i]   <= 1'b0;
      end
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
      r_enc_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= w_word;
        r_mem_err[r_wr_ptr]   <= w_err;
        r_wr_ptr              <= ~r_wr_ptr;
        if (r_enc_cnt != '1) r_enc_cnt <= r_enc_cnt + CNT_W'(1);
        if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < 2'd2);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_instr = out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
  assign out_err   = out_valid ? r_mem_err[r_rd_ptr] : 1'b0;
  assign enc_cnt   = r_enc_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
  import rv_enc_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_class = 4'd0;
  logic [2:0]      in_funct3 = 3'd0;
  logic [6:0]      in_funct7 = 7'd0;
  logic [4:0]      in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [XLEN-1:0] in_imm = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic            out_err;
  logic [15:0]     enc_cnt, err_cnt;

  int n_vec = 0;
  int n_err = 0;

  instr_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_cnt   (enc_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until accepted (bounded).
  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [XLEN-1:0] imm);
    logic acc = 1'b0;
    int   waited = 0;
    in_class = c; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    while (!acc && waited < 20) begin
      acc = in_ready;
      step();
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic err);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(out_instr), 64'(instr));
    chk({tag, "_err"},   64'(out_err),   64'(err));
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_enc_cnt",   64'(enc_cnt),   64'd0);
    chk("rst_err_cnt",   64'(err_cnt),   64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: output appears one cycle after accept with out_ready low
    send(CLS_ARITHI, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 5);
    expect_out("addi", 32'h0050_0093, 1'b0);
    chk("addi_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("addi_drained", 64'(out_valid), 64'd0);

    send(CLS_LUI,    3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
    expect_out("lui", 32'h1234_5137, 1'b0);
    send(CLS_BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, -4);
    expect_out("beq", 32'hFE20_8EE3, 1'b0);
    send(CLS_JAL,    3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 2048);
    expect_out("jal", 32'h0010_00EF, 1'b0);
    send(CLS_STORE,  3'b010, 7'h00, 5'd0, 5'd2, 5'd3, 8);
    expect_out("sw", 32'h0031_2423, 1'b0);
    send(CLS_ARITH,  3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 0);
    expect_out("sub", 32'h4020_81B3, 1'b0);
    send(CLS_ARITHI, 3'b101, 7'h20, 5'd5, 5'd5, 5'd0, 3);
    expect_out("srai", 32'h4032_D293, 1'b0);
    send(CLS_JALR,   3'b000, 7'h00, 5'd0, 5'd1, 5'd0, 0);
    expect_out("jalr", 32'h0000_8067, 1'b0);
    send(CLS_AUIPC,  3'b000, 7'h00, 5'd1, 5'd0, 5'd0, -4096);
    expect_out("auipc", 32'hFFFF_F097, 1'b0);

    // Error cases
    send(CLS_ARITHI, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 2048);
    expect_out("addi_range", NOP_INSTR, 1'b1);
    chk("err_cnt_1", 64'(err_cnt), 64'd1);
    send(CLS_BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 3);
    expect_out("beq_odd", NOP_INSTR, 1'b1);
    send(CLS_ARITHW, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 0);
`ifdef INSTR_ENC_RV64_EN
    expect_out("addw", 32'h0031_00BB, 1'b0);
`else
    expect_out("addw_disabled", NOP_INSTR, 1'b1);
`endif
    send(CLS_ARITHI, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 64);
    expect_out("slli_shamt", NOP_INSTR, 1'b1);
    send(CLS_JAL,    3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 1);
    expect_out("jal_odd", NOP_INSTR, 1'b1);
    send(4'd15,      3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 0);
    expect_out("bad_class", NOP_INSTR, 1'b1);
    send(CLS_LUI,    3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_1001);
    expect_out("lui_low", NOP_INSTR, 1'b1);
    chk("enc_cnt_16", 64'(enc_cnt), 64'd16);
`ifdef INSTR_ENC_RV64_EN
    chk("err_cnt_6", 64'(err_cnt), 64'd6);
`else
    chk("err_cnt_7", 64'(err_cnt), 64'd7);
`endif
    step();
    chk("empty_before_bp", 64'(out_valid), 64'd0);

    // Backpressure: three requests against a stalled output
    out_ready = 1'b0;
    in_class = CLS_ARITHI; in_funct3 = 3'b000; in_funct7 = 7'h00;
    in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_valid = 1'b1;
    in_imm = 1;  step();
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    in_imm = 2;  step();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    in_imm = 3;  step();
    chk("bp_stall_ready", 64'(in_ready), 64'd0);
    expect_out("bp_head_stable", 32'h0010_0093, 1'b0);
    out_ready = 1'b1;
    step();
    expect_out("bp_b", 32'h0020_0093, 1'b0);
    chk("bp_ready_again", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    expect_out("bp_c", 32'h0030_0093, 1'b0);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_enc_cnt", 64'(enc_cnt), 64'd19);

    // Reset with two buffered entries
    out_ready = 1'b0;
    send(CLS_ARITHI, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 7);
    send(CLS_ARITHI, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 8);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_enc_cnt",   64'(enc_cnt),   64'd0);
    chk("mid_rst_err_cnt",   64'(err_cnt),   64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready",  64'(in_ready),  64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    // Saturation with continuous accept at full throughput
    out_ready = 1'b1;
    in_class = CLS_ARITHI; in_funct3 = 3'b000; in_imm = 1;
    in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("sat_enc_cnt", 64'(enc_cnt), 64'hFFFF);
    chk("sat_err_cnt", 64'(err_cnt), 64'd0);
    chk("sat_in_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
